// File: rtl/dma_h2c_desc_issuer.sv
// H2C descriptor issuer: splits read commands into MAX_CHUNK-aligned bypass descriptors
// and limits in-flight descriptors. Optional statistics counters via DMA_ISSUER_STATS_EN.
module dma_h2c_desc_issuer #(
  parameter int unsigned MAX_CHUNK       = 4096,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          pcie_clk,
  input  logic          pcie_aresetn,
  input  logic          s_cmd_valid,
  output logic          s_cmd_ready,
  input  logic [63:0]   s_cmd_addr,
  input  logic [31:0]   s_cmd_len,
  input  logic          h2c_dsc_byp_ready,
  output logic          h2c_dsc_byp_load,
  output logic [63:0]   h2c_dsc_byp_addr,
  output logic [31:0]   h2c_dsc_byp_len,
  input  logic          mon_valid,
  input  logic          mon_ready,
  input  logic          mon_last,
  output logic          cmd_done,
  output logic [CW-1:0] outstanding,
  output logic          busy,
  output logic          credit_err,
  output logic [31:0]   stat_cmds,
  output logic [31:0]   stat_descs
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  localparam logic [63:0]   ChunkMask = 64'(MAX_CHUNK) - 64'd1;
  localparam logic [31:0]   ChunkSize = 32'(MAX_CHUNK);
  localparam logic [CW-1:0] MaxOut    = CW'(MAX_OUTSTANDING);

  state_e        r_state, w_state_d;
  logic [63:0]   r_addr, w_addr_d;
  logic [31:0]   r_rem, w_rem_d;
  logic [31:0]   r_chunk, w_chunk_d;
  logic [CW-1:0] r_out, w_out_d;
  logic          r_err, w_err_d;
  logic          w_load, w_tlast;

  // Bytes left before the next MAX_CHUNK boundary, capped by the remaining length.
  function automatic logic [31:0] f_chunk(input logic [63:0] addr, input logic [31:0] rem);
    logic [31:0] room;
    room = ChunkSize - 32'(addr & ChunkMask);
    return (rem < room) ? rem : room;
  endfunction

  assign w_tlast          = mon_valid & mon_ready & mon_last;
  assign w_load           = (r_state == StIssue) && h2c_dsc_byp_ready && (r_out < MaxOut);
  assign h2c_dsc_byp_load = w_load;
  assign h2c_dsc_byp_addr = r_addr;
  assign h2c_dsc_byp_len  = r_chunk;
  // Gated by reset so ready is low while reset is held.
  assign s_cmd_ready      = (r_state == StIdle) && pcie_aresetn;
  assign cmd_done         = (r_state == StDone);
  assign outstanding      = r_out;
  assign busy             = (r_state != StIdle) || (r_out != '0);
  assign credit_err       = r_err;

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_rem_d   = r_rem;
    w_chunk_d = r_chunk;
    unique case (r_state)
      StIdle: begin
        if (s_cmd_valid) begin
          w_addr_d  = s_cmd_addr;
          w_rem_d   = s_cmd_len;
          w_chunk_d = f_chunk(s_cmd_addr, s_cmd_len);
          w_state_d = (s_cmd_len == 32'd0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (w_load) begin
          w_addr_d  = r_addr + 64'(r_chunk);
          w_rem_d   = r_rem - r_chunk;
          w_chunk_d = f_chunk(w_addr_d, w_rem_d);
          if (r_rem == r_chunk) w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_out_d = r_out;
    w_err_d = r_err;
    if (w_load && !w_tlast) begin
      w_out_d = r_out + CW'(1);
    end else if (!w_load && w_tlast) begin
      if (r_out == '0) w_err_d = 1'b1;
      else             w_out_d = r_out - CW'(1);
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_rem   <= '0;
      r_chunk <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_rem   <= w_rem_d;
      r_chunk <= w_chunk_d;
      r_out   <= w_out_d;
      r_err   <= w_err_d;
    end
  end

`ifdef DMA_ISSUER_STATS_EN
  logic [31:0] r_stat_cmds, r_stat_descs;

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      r_stat_cmds  <= '0;
      r_stat_descs <= '0;
    end else begin
      if (r_state == StDone) r_stat_cmds <= r_stat_cmds + 32'd1;
      if (w_load)            r_stat_descs <= r_stat_descs + 32'd1;
    end
  end

  assign stat_cmds  = r_stat_cmds;
  assign stat_descs = r_stat_descs;
`else
  assign stat_cmds  = '0;
  assign stat_descs = '0;
`endif

endmodule

// File: tb/tb_dma_h2c_desc_issuer.sv
// Directed scoreboard bench for dma_h2c_desc_issuer (MAX_CHUNK 4096, MAX_OUTSTANDING 2).
module tb_dma_h2c_desc_issuer;

  logic        clk, rst_n;
  logic        s_cmd_valid, s_cmd_ready;
  logic [63:0] s_cmd_addr;
  logic [31:0] s_cmd_len;
  logic        byp_ready, byp_load;
  logic [63:0] byp_addr;
  logic [31:0] byp_len;
  logic        mon_v, cmd_done, busy, credit_err;
  logic [1:0]  outstanding;
  logic [31:0] stat_cmds, stat_descs;

  logic        auto_ret, auto_t, man_t;
  assign mon_v = auto_ret ? auto_t : man_t;

  dma_h2c_desc_issuer #(.MAX_CHUNK(4096), .MAX_OUTSTANDING(2)) dut (
    .pcie_clk(clk), .pcie_aresetn(rst_n),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
    .h2c_dsc_byp_ready(byp_ready), .h2c_dsc_byp_load(byp_load),
    .h2c_dsc_byp_addr(byp_addr), .h2c_dsc_byp_len(byp_len),
    .mon_valid(mon_v), .mon_ready(mon_v), .mon_last(mon_v),
    .cmd_done(cmd_done), .outstanding(outstanding), .busy(busy),
    .credit_err(credit_err), .stat_cmds(stat_cmds), .stat_descs(stat_descs)
  );

  typedef struct {
    logic [63:0] a;
    logic [31:0] l;
    int          c;
  } exp_t;

  exp_t q_load[$];
  int   q_done[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_load = -100;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Returns one credit per cycle while anything is in flight.
  always @(posedge clk) begin
    #1;
    auto_t = auto_ret && (outstanding != 2'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops expected descriptors and done pulses as the DUT presents them.
  always @(negedge clk) begin
    exp_t e;
    int   dc;
    if (byp_load) begin
      if (q_load.size() == 0) begin
        chk("unexpected_load", byp_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q_load.pop_front();
        chk("load_addr", byp_addr, e.a);
        chk("load_len", {32'd0, byp_len}, {32'd0, e.l});
        if (e.c >= 0) chk("load_cycle", 64'(cyc), 64'(e.c));
      end
      last_load = cyc;
    end
    if (cmd_done) begin
      if (q_done.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        dc = q_done.pop_front();
        chk("done_cycle", 64'(cyc), 64'((dc < 0) ? last_load + 1 : dc));
      end
    end
  end

  task automatic exp_load(input logic [63:0] a, input logic [31:0] l, input int c);
    exp_t e;
    e.a = a;
    e.l = l;
    e.c = c;
    q_load.push_back(e);
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, output int acc);
    int n;
    n = 0;
    @(posedge clk); #1;
    s_cmd_valid = 1'b1;
    s_cmd_addr  = a;
    s_cmd_len   = l;
    @(negedge clk);
    while (!s_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {63'd0, s_cmd_ready}, 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_stats(input string name, input logic [31:0] c, input logic [31:0] d);
`ifdef DMA_ISSUER_STATS_EN
    chk({name, "_cmds"}, {32'd0, stat_cmds}, {32'd0, c});
    chk({name, "_descs"}, {32'd0, stat_descs}, {32'd0, d});
`else
    chk({name, "_cmds"}, {32'd0, stat_cmds}, 64'd0);
    chk({name, "_descs"}, {32'd0, stat_descs}, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, t;
    rst_n = 1'b0;
    s_cmd_valid = 1'b0;
    s_cmd_addr = '0;
    s_cmd_len = '0;
    byp_ready = 1'b1;
    auto_ret = 1'b0;
    man_t = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {63'd0, s_cmd_ready}, 64'd0);
    chk("rst_load", {63'd0, byp_load}, 64'd0);
    chk("rst_outstanding", {62'd0, outstanding}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, cmd_done}, 64'd0);
    chk("rst_credit_err", {63'd0, credit_err}, 64'd0);
    chk("rst_byp_addr", byp_addr, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {63'd0, s_cmd_ready}, 64'd1);

    // Boundary-straddling command
    auto_ret = 1'b1;
    send_cmd(64'h1000_0F00, 32'h300, acc);
    exp_load(64'h1000_0F00, 32'h100, acc + 1);
    exp_load(64'h1000_1000, 32'h200, acc + 2);
    q_done.push_back(acc + 3);
    wait_idle();

    // Three back-to-back chunks with credits recycled every cycle
    chk_stats("stats_t1", 32'd1, 32'd2);
    send_cmd(64'h0, 32'h2800, acc);
    exp_load(64'h0000, 32'h1000, acc + 1);
    exp_load(64'h1000, 32'h1000, acc + 2);
    exp_load(64'h2000, 32'h0800, acc + 3);
    q_done.push_back(acc + 4);
    wait_idle();
    chk_stats("stats_t2", 32'd2, 32'd5);
    chk("t2_credit_err", {63'd0, credit_err}, 64'd0);

    // Credit exhaustion at MAX_OUTSTANDING = 2
    auto_ret = 1'b0;
    send_cmd(64'h5000_0000, 32'h4000, acc);
    exp_load(64'h5000_0000, 32'h1000, acc + 1);
    exp_load(64'h5000_1000, 32'h1000, acc + 2);
    repeat (3) @(negedge clk);
    chk("stall_outstanding", {62'd0, outstanding}, 64'd2);
    chk("stall_load", {63'd0, byp_load}, 64'd0);
    chk("stall_addr", byp_addr, 64'h5000_2000);
    chk("stall_len", {32'd0, byp_len}, 64'h1000);
    step();
    t = cyc;
    man_t = 1'b1;
    exp_load(64'h5000_2000, 32'h1000, t + 1);
    exp_load(64'h5000_3000, 32'h1000, t + 2);
    q_done.push_back(t + 3);
    step();
    @(negedge clk);
    chk("after_tlast_outstanding", {62'd0, outstanding}, 64'd1);
    step();
    man_t = 1'b0;
    @(negedge clk);
    chk("load_and_tlast_outstanding", {62'd0, outstanding}, 64'd1);
    step();
    @(negedge clk);
    chk("refill_outstanding", {62'd0, outstanding}, 64'd2);
    step();
    man_t = 1'b1;
    step();
    step();
    man_t = 1'b0;
    @(negedge clk);
    chk("drained_outstanding", {62'd0, outstanding}, 64'd0);

    // Zero-length command, then a stray tlast
    send_cmd(64'h1234, 32'h0, acc);
    q_done.push_back(acc + 1);
    @(negedge clk);
    chk("zero_len_ready_low", {63'd0, s_cmd_ready}, 64'd0);
    wait_idle();
    step();
    man_t = 1'b1;
    step();
    man_t = 1'b0;
    @(negedge clk);
    chk("credit_err_set", {63'd0, credit_err}, 64'd1);
    chk("credit_err_outstanding", {62'd0, outstanding}, 64'd0);
    repeat (3) @(negedge clk);
    chk("credit_err_sticky", {63'd0, credit_err}, 64'd1);

    // Bypass ready toggled 1-0-1 mid-command
    auto_ret = 1'b1;
    send_cmd(64'h7000_0800, 32'h1800, acc);
    exp_load(64'h7000_0800, 32'h0800, acc + 1);
    step();
    byp_ready = 1'b0;
    @(negedge clk);
    chk("hold_addr_0", byp_addr, 64'h7000_1000);
    chk("hold_len_0", {32'd0, byp_len}, 64'h1000);
    step();
    @(negedge clk);
    chk("hold_addr_1", byp_addr, 64'h7000_1000);
    chk("hold_len_1", {32'd0, byp_len}, 64'h1000);
    step();
    byp_ready = 1'b1;
    exp_load(64'h7000_1000, 32'h1000, acc + 4);
    q_done.push_back(acc + 5);
    wait_idle();

    // Reset mid-command aborts, then a fresh command starts cleanly
    auto_ret = 1'b0;
    send_cmd(64'h9000_0000, 32'h3000, acc);
    exp_load(64'h9000_0000, 32'h1000, acc + 1);
    exp_load(64'h9000_1000, 32'h1000, acc + 2);
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_load", {63'd0, byp_load}, 64'd0);
    chk("abort_outstanding", {62'd0, outstanding}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_cmd_ready", {63'd0, s_cmd_ready}, 64'd0);
    chk("abort_credit_err", {63'd0, credit_err}, 64'd0);
    chk("abort_addr", byp_addr, 64'd0);
    chk("abort_len", {32'd0, byp_len}, 64'd0);
    chk_stats("abort_stats", 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    send_cmd(64'h0000_0000_ABCD_0010, 32'h20, acc);
    exp_load(64'h0000_0000_ABCD_0010, 32'h20, acc + 1);
    q_done.push_back(acc + 2);
    step();
    step();
    step();
    step();
    man_t = 1'b1;
    step();
    man_t = 1'b0;
    wait_idle();
    chk_stats("fresh_stats", 32'd1, 32'd1);

    repeat (2) @(negedge clk);
    chk("load_queue_empty", 64'(q_load.size()), 64'd0);
    chk("done_queue_empty", 64'(q_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
